// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for regfile_sb.
// Build option: REGFILE_BYPASS_EN enables write-first read forwarding.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;
    localparam int unsigned ZERO_REG = 0;

    // Width able to hold any count from 0 to n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// regfile_scoreboard: pending-write bits, incremental pending count and
// per-port busy lookup.
// Build option: REGFILE_BYPASS_EN suppresses busy on a port whose register
// is being written back this cycle (unless it is also being re-issued).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [$clog2(NREG)-1:0]       wr_addr,
    input  logic                          issue_en,
    input  logic [$clog2(NREG)-1:0]       issue_addr,
    input  logic                          flush,
    input  logic [NRD*$clog2(NREG)-1:0]   rs_addr,
    output logic [NRD-1:0]                rs_busy,
    output logic [$clog2(NREG+1)-1:0]     pending_cnt
);

    localparam int unsigned AW = $clog2(NREG);
    localparam int unsigned CW = cnt_width(NREG);

    logic [NREG-1:0] pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_hit, iss_hit, inc, dec;
    logic [AW-1:0]   rd_a;

    assign wr_hit  = we && (wr_addr != AW'(ZERO_REG));
    assign iss_hit = issue_en && (issue_addr != AW'(ZERO_REG));

    // Next pending vector and count; flush first, then writeback clear, then issue (issue wins).
    always_comb begin
        pend_d = flush ? '0 : pend_q;
        if (wr_hit)
            pend_d[wr_addr] = 1'b0;
        if (iss_hit)
            pend_d[issue_addr] = 1'b1;

        inc = iss_hit && !pend_q[issue_addr];
        dec = wr_hit && pend_q[wr_addr] && !(iss_hit && (issue_addr == wr_addr));
        if (flush)
            cnt_d = iss_hit ? CW'(1) : '0;
        else
            cnt_d = cnt_q + CW'(inc) - CW'(dec);
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    // Per-port busy lookup; register 0 is never marked so needs no special case.
    always_comb begin
        rs_busy = '0;
        rd_a    = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_a = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (rd_a == wr_addr))
                rs_busy[i] = iss_hit && (issue_addr == rd_a);
            else
                rs_busy[i] = pend_q[rd_a];
`else
            rs_busy[i] = pend_q[rd_a];
`endif
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: NRD-read / 1-write register file with pending-write scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writeback data to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned NRD  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          we,
    input  logic [$clog2(NREG)-1:0]       wr_addr,
    input  logic [XLEN-1:0]               wr_data,
    input  logic [NRD*$clog2(NREG)-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0]           rs_data,
    output logic [NRD-1:0]                rs_busy,
    input  logic                          issue_en,
    input  logic [$clog2(NREG)-1:0]       issue_addr,
    input  logic                          flush,
    output logic [$clog2(NREG+1)-1:0]     pending_cnt
);

    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] mem_q [NREG];
    logic            wr_hit;
    logic [AW-1:0]   rd_a;
    logic [XLEN-1:0] rd_w;

    assign wr_hit = we && (wr_addr != AW'(ZERO_REG));

    // Data array; entry 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                mem_q[i] <= '0;
        end else if (wr_hit) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Combinational read muxes with optional write-first forwarding.
    always_comb begin
        rs_data = '0;
        rd_a    = '0;
        rd_w    = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_a = rs_addr[i*AW +: AW];
            rd_w = (rd_a == AW'(ZERO_REG)) ? '0 : mem_q[rd_a];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (rd_a == wr_addr))
                rd_w = wr_data;
`endif
            rs_data[i*XLEN +: XLEN] = rd_w;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .wr_addr     (wr_addr),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .rs_addr     (rs_addr),
        .rs_busy     (rs_busy),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (default parameters, NRD=2).
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 we;
    logic [AW-1:0]        wr_addr;
    logic [XLEN-1:0]      wr_data;
    logic [NRD*AW-1:0]    rs_addr;
    logic [NRD*XLEN-1:0]  rs_data;
    logic [NRD-1:0]       rs_busy;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    logic                 flush;
    logic [CW-1:0]        pending_cnt;

    int total = 0;
    int bad   = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [4:0]    wa;
        logic [31:0]   wd;
        logic          ie;
        logic [4:0]    ia;
        logic          fl;
        logic [4:0]    ra0;
        logic [4:0]    ra1;
        logic [31:0]   ed0;
        logic [31:0]   ed1;
        logic [1:0]    ebusy;
        logic [5:0]    ecnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        we = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [1:0] b, input logic [5:0] c);
        chk({tag, ".d0"},   rs_data[31:0], d0);
        chk({tag, ".d1"},   rs_data[63:32], d1);
        chk({tag, ".busy"}, 32'(rs_busy), 32'(b));
        chk({tag, ".cnt"},  32'(pending_cnt), 32'(c));
    endtask

    // Drive one edge's worth of operations, then quiesce and point reads at r0/r1.
    task automatic do_edge(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                           input logic ie, input logic [4:0] ia, input logic fl,
                           input logic [4:0] r0, input logic [4:0] r1);
        @(negedge clk);
        we = w; wr_addr = wa; wr_data = wd;
        issue_en = ie; issue_addr = ia; flush = fl;
        @(posedge clk);
        #1;
        idle_inputs();
        rs_addr = {r1, r0};
        #1;
    endtask

    initial begin
        vecs[0]  = '{1, 2,  32'h11111111, 0, 0, 0, 2, 0,  32'h11111111, 32'h0,        2'b00, 1};
        vecs[0].ecnt = 0;
        vecs[1]  = '{1, 3,  32'h22222222, 0, 0, 0, 3, 2,  32'h22222222, 32'h11111111, 2'b00, 0};
        vecs[2]  = '{0, 0,  32'h0,        1, 5, 0, 5, 2,  32'h0,        32'h11111111, 2'b01, 1};
        vecs[3]  = '{0, 0,  32'h0,        0, 0, 0, 5, 5,  32'h0,        32'h0,        2'b11, 1};
        vecs[4]  = '{1, 5,  32'hDEADBEEF, 0, 0, 0, 5, 3,  32'hDEADBEEF, 32'h22222222, 2'b00, 0};
        vecs[5]  = '{1, 0,  32'h00001234, 1, 0, 0, 0, 0,  32'h0,        32'h0,        2'b00, 0};
        vecs[6]  = '{0, 0,  32'h0,        1, 7, 0, 7, 7,  32'h0,        32'h0,        2'b11, 1};
        vecs[7]  = '{1, 7,  32'h00000077, 1, 7, 0, 7, 5,  32'h00000077, 32'hDEADBEEF, 2'b01, 1};
        vecs[8]  = '{1, 7,  32'h00000088, 1, 8, 0, 7, 8,  32'h00000088, 32'h0,        2'b10, 1};
        vecs[9]  = '{1, 8,  32'h00000099, 1, 3, 1, 3, 8,  32'h22222222, 32'h00000099, 2'b01, 1};
        vecs[10] = '{1, 3,  32'h00000033, 0, 0, 0, 3, 3,  32'h00000033, 32'h00000033, 2'b00, 0};
        vecs[11] = '{0, 0,  32'h0,        1, 31, 0, 31, 30, 32'h0,      32'h0,        2'b01, 1};
        vecs[12] = '{0, 0,  32'h0,        0, 0, 1, 31, 30, 32'h0,       32'h0,        2'b00, 0};

        idle_inputs();
        rs_addr = {5'd2, 5'd1};
        rst_n = 1'b0;
        #12;
        chk_state("reset", 32'h0, 32'h0, 2'b00, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_edge(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ie, vecs[i].ia, vecs[i].fl,
                    vecs[i].ra0, vecs[i].ra1);
            chk_state($sformatf("vec%0d", i), vecs[i].ed0, vecs[i].ed1, vecs[i].ebusy, vecs[i].ecnt);
        end

        // Issue x1..x31 on consecutive edges, then flush with a same-edge issue of x3.
        for (int r = 1; r < 32; r++)
            do_edge(0, 0, 0, 1, 5'(r), 0, 5'(r), 5'd1);
        chk("fill.cnt", 32'(pending_cnt), 32'd31);
        chk("fill.busy", 32'(rs_busy), 32'd3);
        do_edge(0, 0, 0, 1, 5'd3, 1, 5'd3, 5'd4);
        chk_state("flush_issue", 32'h00000033, 32'h0, 2'b01, 6'd1);
        do_edge(1, 3, 32'h0, 0, 0, 0, 5'd3, 5'd4);
        chk("clr3.cnt", 32'(pending_cnt), 32'd0);

        // Forwarding: x9 holds 0x01 and is pending; write 0xA5A5A5A5 while reading it on both ports.
        do_edge(1, 9, 32'h00000001, 1, 5'd9, 0, 5'd9, 5'd9);
        chk_state("pre_byp", 32'h1, 32'h1, 2'b11, 6'd1);
        @(negedge clk);
        we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk_state("byp_same", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 6'd1);
`else
        chk_state("byp_same", 32'h00000001, 32'h00000001, 2'b11, 6'd1);
`endif
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        chk_state("byp_after", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 6'd0);

        // Asynchronous reset mid-cycle with a register pending and an issue in flight.
        do_edge(0, 0, 0, 1, 5'd10, 0, 5'd9, 5'd10);
        chk("pre_rst.cnt", 32'(pending_cnt), 32'd1);
        @(negedge clk);
        issue_en = 1'b1; issue_addr = 5'd11;
        we = 1'b1; wr_addr = 5'd12; wr_data = 32'hFFFFFFFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 32'h0, 32'h0, 2'b00, 6'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        rs_addr = {5'd12, 5'd11};
        #1;
        chk_state("rst_hold", 32'h0, 32'h0, 2'b00, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_edge(0, 0, 0, 0, 0, 0, 5'd11, 5'd12);
        chk_state("post_rst", 32'h0, 32'h0, 2'b00, 6'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with N read ports, one write port, and a per-register pending-write scoreboard. It replaces the fixed 32×32, two-read-port file for the pipelined core generation. Reads are combinational and write is synchronous, as before. Added here: asynchronous reset, issue-time scoreboard marking, writeback clear, pipeline flush, and a live count of outstanding writes for the hazard unit.

## Interface
Parameters:
- XLEN, 32, data width of every register
- NREG, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREG), register address width (derived, not overridable)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  writeback enable
- wr_addr  in  AW  writeback register index
- wr_data  in  XLEN  writeback data
- rs_addr  in  NRD×AW  read addresses, one per port
- rs_data  out  NRD×XLEN  read data, one per port
- rs_busy  out  NRD  1 = register on that port has an outstanding write
- issue_en  in  1  an instruction writing issue_addr has issued
- issue_addr  in  AW  destination register of the issued instruction
- flush  in  1  clear all pending marks (pipeline squash)
- pending_cnt  out  $clog2(NREG+1)  number of registers currently marked pending

## Operation
- Register 0 is hardwired: it reads 0 and reports busy 0. A write to it is ignored, and an issue to it marks nothing.
- Write: on a rising edge with we=1 and wr_addr≠0, mem[wr_addr] ← wr_data. If that register is pending, its pending bit clears.
- A write to a non-pending register updates data only and does not change pending_cnt.
- Issue: on a rising edge with issue_en=1 and issue_addr≠0, pending[issue_addr] ← 1.
- Issue to an already-pending register (WAW) keeps the bit at 1 and does not change the count.
- Same edge, issue and write to the same register: the issue wins, so the bit stays or becomes 1. The write data still commits. The count changes by +1 only if the bit was 0 before the edge.
- Flush: on a rising edge with flush=1, all pending bits clear.
  - An issue on the same edge is applied after the flush, so that bit is 1 and pending_cnt = 1.
  - A write on the same edge still commits its data.
- pending_cnt always equals the population count of the pending bits. It updates incrementally (+1, −1, 0, or set on flush) and must never wrap.
- rs_busy[i] = pending[rs_addr[i]], subject to the bypass rule in Configuration.
- All read ports are independent; every port may read the same address.

## Timing
- Reset (rst_n=0, asynchronous): all mem entries become 0, all pending bits become 0, pending_cnt = 0.
  - Consequently rs_data = 0 and rs_busy = 0 on every port while reset is held.
  - Deassertion is synchronised externally, and the first edge after release operates normally.
- Reset asserted mid-operation discards any in-flight write or issue on that edge.
- Read latency is 0 cycles (combinational from rs_addr). Write latency is 1 edge; issue, clear and flush are also 1 edge.
- There is no handshake. Every asserted enable is consumed on the edge where it is sampled.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding.
  - When we=1, wr_addr≠0 and rs_addr[i]==wr_addr, rs_data[i] = wr_data in the same cycle.
  - In that case rs_busy[i] = 0, unless issue_en targets the same register in that cycle.
- REGFILE_BYPASS_EN undefined: read-old behaviour.
  - rs_data shows the pre-edge value.
  - rs_busy reflects the pending bit before the edge.
- The scoreboard and flush logic are identical in both builds.

## Structure
- Package regfile_pkg holds:
  - XLEN_DEF and NREG_DEF
  - a zero-register constant
  - a function computing the count width
- Sub-module regfile_scoreboard holds the pending bit vector, the issue/clear/flush priority logic, the pending_cnt counter, and the rs_busy lookup.
- The top level holds the data array, the read muxes and the bypass.

## Test plan
- Reset: preload via writes, assert rst_n=0 mid-cycle → all rs_data = 0, rs_busy = 0, pending_cnt = 0 immediately, without waiting for a clock edge.
- Issue x5 then write x5 = 0xDEADBEEF two cycles later → busy 1 for 2 cycles, then 0. Read returns 0xDEADBEEF; pending_cnt goes 0→1→0.
- Same-edge issue and write to x7 (x7 already pending) → x7 stays busy, data updated, pending_cnt unchanged.
- Write x0 = 0x1234 and issue x0 → reads 0, busy 0, pending_cnt 0.
- Issue x1..x31 on successive edges → pending_cnt = 31. Then flush together with issue x3 → pending_cnt = 1 and only x3 busy.
- Bypass: write x9 = 0xA5A5A5A5 while reading x9 on all NRD ports.
  - With REGFILE_BYPASS_EN: same-cycle 0xA5A5A5A5 on every port.
  - Without it: the old value, with the new value after the edge.
